// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   - source IDs stored in the in-flight ID FIFO
//   - size encodings carried on the *_size buses
//   - arbiter state enum
//   - request bundle captured when a grant has to be held (lock)
package mem_arb_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Widths of the stored request bundle; the arbiter's AW/DW must not exceed these.
  localparam int unsigned REQ_AW = 32;
  localparam int unsigned REQ_DW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLockI,
    StLockD
  } arb_state_e;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [REQ_DW/8-1:0]   wstrb;
    logic [REQ_AW-1:0]     addr;
    logic [REQ_DW-1:0]     wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-flight source-ID FIFO for the memory port arbiter.
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the FIFO)
//   push, push_id   enqueue one ID (ignored when full unless a pop happens the same cycle)
//   pop             dequeue the head (ignored when empty)
//   head_id         ID at the head, valid when !empty
//   full, empty     occupancy flags
//   count           number of stored IDs, 0..Depth
module arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            push_id,
  input  logic            pop,
  output logic            head_id,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign count   = count_q;
  assign head_id = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  // When full, the slot being freed by a same-cycle pop is the one written.
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between the fetch (inst_*) and load/store (data_*)
// requesters. Requests pass through with zero latency; a grant not accepted in its
// first cycle is locked and replayed from a registered copy until mem_addr_ok.
// Accepted requests push their source ID into an in-order FIFO, which routes each
// mem_data_ok back to the originating requester.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   inst_* / data_*                requester sides (req, wr, size, wstrb, addr, wdata in;
//                                  addr_ok, data_ok, rdata out)
//   mem_*                          downstream port (req/wr/size/wstrb/addr/wdata out;
//                                  addr_ok, data_ok, rdata in)
// Configuration:
//   ARB_RR_EN  defined: round-robin on simultaneous requests; undefined: data over inst.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned OUTST = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            inst_req,
  input  logic            inst_wr,
  input  logic [1:0]      inst_size,
  input  logic [DW/8-1:0] inst_wstrb,
  input  logic [AW-1:0]   inst_addr,
  input  logic [DW-1:0]   inst_wdata,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [DW-1:0]   inst_rdata,

  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [DW-1:0]   data_rdata,

  output logic            mem_req,
  output logic            mem_wr,
  output logic [1:0]      mem_size,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned CntW = $clog2(OUTST) + 1;

  arb_state_e      state_q, state_d;
  mem_req_t        inst_bundle, data_bundle, sel_bundle, lock_q;
  logic            mem_src, idle_src, tie_src;
  logic            capture;
  logic            fifo_full, fifo_empty, fifo_head;
  logic [CntW-1:0] fifo_count;
  logic            push, pop, can_grant;

  always_comb begin
    inst_bundle                = '0;
    inst_bundle.wr             = inst_wr;
    inst_bundle.size           = inst_size;
    inst_bundle.wstrb[DW/8-1:0] = inst_wstrb;
    inst_bundle.addr[AW-1:0]   = inst_addr;
    inst_bundle.wdata[DW-1:0]  = inst_wdata;
    data_bundle                = '0;
    data_bundle.wr             = data_wr;
    data_bundle.size           = data_size;
    data_bundle.wstrb[DW/8-1:0] = data_wstrb;
    data_bundle.addr[AW-1:0]   = data_addr;
    data_bundle.wdata[DW-1:0]  = data_wdata;
  end

  assign pop       = mem_data_ok & ~fifo_empty;
  // A response retiring this cycle frees a slot for a new grant.
  assign can_grant = ~fifo_full | pop;

`ifdef ARB_RR_EN
  logic prio_data_q;  // 1: data wins the next tie

  assign tie_src = prio_data_q ? SRC_DATA : SRC_INST;

  // The grant is committed in the tie cycle (a lock cannot change it), so the
  // loser gets priority from here on.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_data_q <= 1'b1;
    end else if (state_q == StIdle && can_grant && inst_req && data_req) begin
      prio_data_q <= (tie_src == SRC_INST);
    end
  end
`else
  assign tie_src = SRC_DATA;
`endif

  always_comb begin
    if (inst_req && data_req) idle_src = tie_src;
    else if (data_req)        idle_src = SRC_DATA;
    else                      idle_src = SRC_INST;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_src    = SRC_INST;
    sel_bundle = inst_bundle;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (can_grant && (inst_req || data_req)) begin
          mem_req    = 1'b1;
          mem_src    = idle_src;
          sel_bundle = (idle_src == SRC_DATA) ? data_bundle : inst_bundle;
          if (!mem_addr_ok) begin
            capture = 1'b1;
            state_d = (idle_src == SRC_DATA) ? StLockD : StLockI;
          end
        end
      end
      // Locked: the slot was reserved at grant time, so the full check does not apply.
      StLockI, StLockD: begin
        mem_req    = 1'b1;
        mem_src    = (state_q == StLockD) ? SRC_DATA : SRC_INST;
        sel_bundle = lock_q;
        if (mem_addr_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (capture) lock_q <= sel_bundle;
  end

  assign mem_wr    = sel_bundle.wr;
  assign mem_size  = sel_bundle.size;
  assign mem_wstrb = sel_bundle.wstrb[DW/8-1:0];
  assign mem_addr  = sel_bundle.addr[AW-1:0];
  assign mem_wdata = sel_bundle.wdata[DW-1:0];

  assign push         = mem_req & mem_addr_ok;
  assign inst_addr_ok = push & (mem_src == SRC_INST);
  assign data_addr_ok = push & (mem_src == SRC_DATA);

  assign inst_data_ok = pop & (fifo_head == SRC_INST);
  assign data_data_ok = pop & (fifo_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  arb_id_fifo #(
    .Depth (OUTST),
    .CntW  (CntW)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (mem_src),
    .pop     (mem_data_ok),
    .head_id (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  count_bound_a: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CntW'(OUTST));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned OUTST = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            inst_req, inst_wr, data_req, data_wr;
  logic [1:0]      inst_size, data_size;
  logic [DW/8-1:0] inst_wstrb, data_wstrb;
  logic [AW-1:0]   inst_addr, data_addr;
  logic [DW-1:0]   inst_wdata, data_wdata;
  logic            inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0]   inst_rdata, data_rdata;
  logic            mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]      mem_size;
  logic [DW/8-1:0] mem_wstrb;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .OUTST (OUTST),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of in-flight source IDs plus the request held by a pending lock.
  bit       q_src[$];
  bit       m_locked;
  bit       m_lock_src;
  bit       m_prio_data = 1'b1;
  mem_req_t m_held;

  logic [1:0] sizes [3] = '{SIZE_BYTE, SIZE_HALF, SIZE_WORD};

  task automatic run_cycle(input bit rst, input bit ir, input bit dr, input bit aok, input bit dok);
    bit       do_pop, exp_req, src, head;
    mem_req_t ireq, dreq, exp_f;
    @(negedge clk);
    reset       = rst;
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    inst_wr     = 1'($urandom);
    inst_size   = sizes[$urandom_range(2)];
    inst_wstrb  = 4'($urandom);
    inst_addr   = 32'($urandom);
    inst_wdata  = 32'($urandom);
    data_wr     = 1'($urandom);
    data_size   = sizes[$urandom_range(2)];
    data_wstrb  = 4'($urandom);
    data_addr   = 32'($urandom);
    data_wdata  = 32'($urandom);
    mem_rdata   = 32'($urandom);
    ireq = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata};
    dreq = '{wr: data_wr, size: data_size, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};
    #1;
    if (rst) begin
      q_src.delete();
      m_locked    = 1'b0;
      m_prio_data = 1'b1;
    end else begin
      do_pop  = dok && (q_src.size() > 0);
      head    = (q_src.size() > 0) ? q_src[0] : SRC_INST;
      exp_req = 1'b0;
      src     = SRC_INST;
      exp_f   = ireq;
      if (m_locked) begin
        exp_req = 1'b1;
        src     = m_lock_src;
        exp_f   = m_held;
      end else if ((q_src.size() < OUTST || do_pop) && (ir || dr)) begin
        exp_req = 1'b1;
        src     = dr ? SRC_DATA : SRC_INST;
`ifdef ARB_RR_EN
        if (ir && dr) begin
          src         = m_prio_data ? SRC_DATA : SRC_INST;
          m_prio_data = (src == SRC_INST);
        end
`endif
        exp_f = (src == SRC_DATA) ? dreq : ireq;
      end
      check_eq("mem_req", mem_req, exp_req);
      if (exp_req) begin
        check_eq("mem_addr", mem_addr, exp_f.addr);
        check_eq("mem_wdata", mem_wdata, exp_f.wdata);
        check_eq("mem_wr", mem_wr, exp_f.wr);
        check_eq("mem_size", mem_size, exp_f.size);
        check_eq("mem_wstrb", mem_wstrb, exp_f.wstrb);
      end
      check_eq("inst_addr_ok", inst_addr_ok, exp_req && aok && src == SRC_INST);
      check_eq("data_addr_ok", data_addr_ok, exp_req && aok && src == SRC_DATA);
      check_eq("inst_data_ok", inst_data_ok, do_pop && head == SRC_INST);
      check_eq("data_data_ok", data_data_ok, do_pop && head == SRC_DATA);
      check_eq("inst_rdata", inst_rdata, mem_rdata);
      check_eq("data_rdata", data_rdata, mem_rdata);
      if (do_pop) void'(q_src.pop_front());
      if (exp_req && aok) begin
        q_src.push_back(src);
        m_locked = 1'b0;
      end else if (exp_req && !m_locked) begin
        m_locked   = 1'b1;
        m_lock_src = src;
        m_held     = exp_f;
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset state, including a stale response with an empty FIFO.
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Inst-only stream, responses one cycle behind.
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    drain(2);

    // Conflict, twice.
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    drain(3);

    // Lock hold with inst competing and the locked requester dropping req.
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drain(3);

    // Full: four accepted, fifth blocked, then issued alongside a response.
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    drain(5);

    // Interleaved I,D,I,D then four responses.
    for (int i = 0; i < 4; i++) run_cycle(1'b0, i % 2 == 0, i % 2 == 1, 1'b1, 1'b0);
    drain(4);

    // Reset mid-flight, then a stale response.
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      run_cycle($urandom_range(199) == 0, $urandom_range(99) < 55, $urandom_range(99) < 55,
                $urandom_range(99) < 60, $urandom_range(99) < 45);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
